// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample path.
// Includes the fetch FSM state encoding used by pull-style sample consumers.
package audio_pkg;

    localparam int CODE_WIDTH_DEFAULT = 10;
    localparam int CLK_HZ             = 125_000_000;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_WAIT    = 2'd2,
        FETCH_CAPTURE = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: dout always presents the head entry.
// Pointers wrap naturally; occupancy is kept in its own counter.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_do_push;
    logic             w_do_pop;

    always_comb begin
        full      = (r_level == LVL_FULL);
        empty     = (r_level == '0);
        w_do_push = push && !full;
        w_do_pop  = pop && !empty;
        dout      = r_mem[r_rd_ptr];
        level     = r_level;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (PTR_W + 1)'(1);
                2'b01:   r_level <= r_level - (PTR_W + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage carries no reset; entries are only read once they are counted.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/pcm_pull_dac.sv
// Pulls samples from a tone generator into a prefetch FIFO and plays one
// sample per PWM window as a duty cycle on pwm.
module pcm_pull_dac
    import audio_pkg::*;
#(
    parameter int CODE_WIDTH        = CODE_WIDTH_DEFAULT,
    parameter int CYCLES_PER_WINDOW = 1024,
    parameter int FIFO_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [CODE_WIDTH-1:0]         code,
    output logic                          next_sample,
    output logic                          pwm,
    output logic                          underflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [1:0]                    o_dbg_fetch_state
);

    // Pull handshake: next_sample is a one-cycle request. The generator
    // updates code on the edge that samples the request, and code is
    // captured two edges later. There is no back-pressure on the generator:
    // a request is issued only after a FIFO slot has been reserved for it.

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = (CYCLES_PER_WINDOW > 1) ? $clog2(CYCLES_PER_WINDOW) : 1;
    localparam int CMP_W = (CODE_WIDTH > CNT_W + 1) ? CODE_WIDTH : CNT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_WINDOW - 1);
    localparam logic [CMP_W-1:0] DUTY_MAX  = CMP_W'(CYCLES_PER_WINDOW);
    localparam logic [LVL_W:0]   DEPTH_CMP = (LVL_W + 1)'(FIFO_DEPTH);

    fetch_state_e          r_state;
    fetch_state_e          w_state_next;
    logic                  w_in_flight;
    logic                  w_admit;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [LVL_W-1:0]      w_level;
    logic [LVL_W:0]        w_committed;
    logic [CODE_WIDTH-1:0] w_fifo_dout;
    logic [CODE_WIDTH-1:0] w_duty_next;
    logic [CMP_W-1:0]      w_duty_ext;
    logic [CMP_W-1:0]      w_duty_sat;
    logic                  w_win_start;
    logic                  w_pwm_next;

    logic [CNT_W-1:0]      r_cnt;
    logic [CODE_WIDTH-1:0] r_duty;
    logic                  r_pwm;
    logic                  r_underflow;

    sync_fifo #(
        .WIDTH (CODE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (code),
        .dout  (w_fifo_dout),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    // Admission counts the sample still in flight so the FIFO cannot overflow.
    always_comb begin
        w_in_flight = (r_state != FETCH_IDLE);
        w_committed = {1'b0, w_level} + (LVL_W + 1)'(w_in_flight);
        w_admit     = enable && !w_full && (w_committed < DEPTH_CMP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // CAPTURE chains straight into REQ so back-to-back fetches keep a 3-cycle cadence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE:    if (w_admit) w_state_next = FETCH_REQ;
            FETCH_REQ:     w_state_next = FETCH_WAIT;
            FETCH_WAIT:    w_state_next = FETCH_CAPTURE;
            FETCH_CAPTURE: w_state_next = w_admit ? FETCH_REQ : FETCH_IDLE;
            default:       w_state_next = FETCH_IDLE;
        endcase
    end

    always_comb begin
        next_sample       = (r_state == FETCH_REQ);
        w_push            = (r_state == FETCH_CAPTURE);
        o_dbg_fetch_state = r_state;
    end

    // The popped head drives pwm on the window-start edge itself.
    always_comb begin
        w_win_start = enable && (r_cnt == '0);
        w_pop       = w_win_start && !w_empty;
        w_duty_next = w_pop ? w_fifo_dout : r_duty;
        w_duty_ext  = CMP_W'(w_duty_next);
        w_duty_sat  = (w_duty_ext > DUTY_MAX) ? DUTY_MAX : w_duty_ext;
        w_pwm_next  = (CMP_W'(r_cnt) < w_duty_sat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_duty      <= '0;
            r_pwm       <= 1'b0;
            r_underflow <= 1'b0;
        end else if (enable) begin
            r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_duty <= w_duty_next;
            r_pwm  <= w_pwm_next;
            if (w_win_start && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_comb begin
        pwm        = r_pwm;
        underflow  = r_underflow;
        fifo_level = w_level;
    end

endmodule
